// File: rtl/psram_qspi_ctrl_if.sv
// psram_qspi_ctrl_if: single-request valid/ready bus with a one-cycle response pulse.
// Rev 1.0
`default_nettype none

interface psram_qspi_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [23:0] req_addr;
   logic [1:0]  req_size;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;

   modport master (
      output req_valid, req_wen, req_addr, req_size, req_wdata,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_wen, req_addr, req_size, req_wdata,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

`default_nettype wire

// File: rtl/psram_qspi_ctrl.sv
// psram_qspi_ctrl: QSPI master issuing one EBh quad read or 38h quad write per request.
// Rev 1.0
`default_nettype none

module psram_qspi_ctrl #(
   parameter int DUMMY_EDGES = 6,
   parameter int CE_GAP      = 2
) (
   input  logic             clock_i,
   input  logic             reset_i,
   psram_qspi_ctrl_if.slave bus,
   output logic             psram_sck_o,
   output logic             psram_ce_n_o,
   output logic [3:0]       psram_dout_o,
   output logic [3:0]       psram_douten_o,
   input  logic [3:0]       psram_din_i
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CMD  = 3'd1;
   localparam logic [2:0] S_ADDR = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_RD   = 3'd4;
   localparam logic [2:0] S_WR   = 3'd5;
   localparam logic [2:0] S_GAP  = 3'd6;

   localparam int CW = ($clog2(DUMMY_EDGES + 1) > 3) ? $clog2(DUMMY_EDGES + 1) : 3;
   localparam int GW = $clog2(CE_GAP + 1);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          sck_q, sck_d;
   logic          ce_n_q, ce_n_d;
   logic [3:0]    dout_q, dout_d;
   logic [3:0]    douten_q, douten_d;
   logic          wen_q, wen_d;
   logic [23:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [2:0]    wlast_q, wlast_d;
   logic [31:0]   acc_q, acc_d;
   logic          resp_valid_q, resp_valid_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          adv;
   logic          last;

   // Data nibble k of a 32-bit word: byte k/2, high nibble first.
   function automatic logic [4:0] nib_lsb(input logic [2:0] c);
      return {c[2:1], ~c[0], 2'b00};
   endfunction

   // {douten, dout} presented during the low phase of a given edge.
   function automatic logic [7:0] drive(input logic [2:0] st, input logic [2:0] c,
                                        input logic wen, input logic [23:0] addr,
                                        input logic [31:0] wdata);
      logic [7:0] cmd;
      logic [4:0] alsb;
      cmd   = wen ? 8'h38 : 8'hEB;
      alsb  = 5'd20 - {c, 2'b00};
      case (st)
         S_CMD:   drive = {4'b0001, 3'b000, cmd[3'd7 - c]};
         S_ADDR:  drive = {4'b1111, addr[alsb +: 4]};
         S_WR:    drive = {4'b1111, wdata[nib_lsb(c) +: 4]};
         default: drive = 8'h00;
      endcase
   endfunction

   assign last = ((state_q == S_RD) && (cnt_q == CW'(7))) ||
                 ((state_q == S_WR) && (cnt_q == CW'(wlast_q)));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      gap_d        = gap_q;
      sck_d        = sck_q;
      ce_n_d       = ce_n_q;
      dout_d       = dout_q;
      douten_d     = douten_q;
      wen_d        = wen_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wlast_d      = wlast_q;
      acc_d        = acc_q;
      resp_valid_d = 1'b0;
      rdata_d      = rdata_q;
      adv          = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               wen_d   = bus.req_wen;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               wlast_d = (bus.req_size == 2'd0) ? 3'd1 : (bus.req_size == 2'd1) ? 3'd3 : 3'd7;
               acc_d   = '0;
               state_d = S_CMD;
               cnt_d   = '0;
               ce_n_d  = 1'b0;
               sck_d   = 1'b0;
               adv     = 1'b1;
            end
         end
         S_GAP: begin
            if (gap_q == GW'(CE_GAP - 2)) state_d = S_IDLE;
            else                          gap_d   = gap_q + GW'(1);
         end
         default: begin
            if (!sck_q) begin
               sck_d = 1'b1;
            end else begin
               sck_d = 1'b0;
               if (state_q == S_RD) acc_d[nib_lsb(cnt_q[2:0]) +: 4] = psram_din_i;
               if (last) begin
                  ce_n_d       = 1'b1;
                  dout_d       = 4'h0;
                  douten_d     = 4'h0;
                  resp_valid_d = 1'b1;
                  rdata_d      = wen_q ? 32'h0 : acc_d;
                  state_d      = S_GAP;
                  gap_d        = '0;
               end else begin
                  adv   = 1'b1;
                  cnt_d = cnt_q + CW'(1);
                  case (state_q)
                     S_CMD: if (cnt_q == CW'(7)) begin
                        state_d = S_ADDR;
                        cnt_d   = '0;
                     end
                     S_ADDR: if (cnt_q == CW'(5)) begin
                        state_d = wen_q ? S_WR : ((DUMMY_EDGES == 0) ? S_RD : S_WAIT);
                        cnt_d   = '0;
                     end
                     S_WAIT: if (cnt_q == CW'(DUMMY_EDGES - 1)) begin
                        state_d = S_RD;
                        cnt_d   = '0;
                     end
                     default: ;
                  endcase
               end
            end
         end
      endcase
      if (adv) {douten_d, dout_d} = drive(state_d, cnt_d[2:0], wen_d, addr_d, wdata_d);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         gap_q        <= '0;
         sck_q        <= 1'b0;
         ce_n_q       <= 1'b1;
         dout_q       <= 4'h0;
         douten_q     <= 4'h0;
         wen_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wlast_q      <= '0;
         acc_q        <= '0;
         resp_valid_q <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         gap_q        <= gap_d;
         sck_q        <= sck_d;
         ce_n_q       <= ce_n_d;
         dout_q       <= dout_d;
         douten_q     <= douten_d;
         wen_q        <= wen_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wlast_q      <= wlast_d;
         acc_q        <= acc_d;
         resp_valid_q <= resp_valid_d;
         rdata_q      <= rdata_d;
      end
   end

   assign bus.req_ready   = (state_q == S_IDLE);
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_rdata  = rdata_q;
   assign psram_sck_o     = sck_q;
   assign psram_ce_n_o    = ce_n_q;
   assign psram_dout_o    = dout_q;
   assign psram_douten_o  = douten_q;

endmodule

`default_nettype wire
